// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data filter front end.
// Holds the filter function codes, the record geometry and the feeder state type.
package iotdf_pkg;

  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;
  localparam logic [2:0] FN_EXT  = 3'd4;
  localparam logic [2:0] FN_EXC  = 3'd5;
  localparam logic [2:0] FN_PMAX = 3'd6;
  localparam logic [2:0] FN_PMIN = 3'd7;

  localparam int unsigned BYTES_PER_REC = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StHalt
  } feeder_state_e;

endpackage

// File: rtl/iot_rec_fifo.sv
// Synchronous FIFO of 128-bit sensor records.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push, wdata    write a record (caller guarantees !full)
//   pop, rdata     rdata is the head record; pop advances past it (caller guarantees !empty)
//   count          registered occupancy, 0..DEPTH
//   full, empty    decoded from count
module iot_rec_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [127:0]             wdata,
  input  logic                     pop,
  output logic [127:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [127:0]  mem_q [DEPTH];
  logic [127:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/iot_stream_feeder.sv
// Upstream feeder for the IoT data filter.
// Buffers 128-bit records and serialises each as 16 bytes, MSB byte first, on a
// gapless byte stream. Once the stream has started the filter counts bytes
// free-running, so running dry at a record boundary halts the feeder for good.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_valid, s_ready, s_data   record input handshake
//   cfg_fn, cfg_load           function code, latched only while idle
//   busy                       filter back-pressure, stalls byte emission
//   in_en, iot_in, fn_sel      registered byte stream and function select
//   underrun                   sticky: FIFO empty at a record boundary mid-stream
//   rec_cnt                    records fully sent since reset, wrapping
module iot_stream_feeder
  import iotdf_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_THRESH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [2:0]   cfg_fn,
  input  logic         cfg_load,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  output logic         underrun,
  output logic [15:0]  rec_cnt
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] THRESH  = CW'(START_THRESH);
  localparam logic [3:0] LAST_BYTE  = 4'(BYTES_PER_REC - 1);

  feeder_state_e state_q, state_d;
  logic [127:0]  shift_q, shift_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic          in_en_q, in_en_d;
  logic [7:0]    iot_in_q, iot_in_d;
  logic [2:0]    fn_sel_q, fn_sel_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   rec_cnt_q, rec_cnt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [127:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && !fifo_full;

  iot_rec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(s_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    in_en_d    = 1'b0;
    iot_in_d   = iot_in_q;
    fn_sel_d   = fn_sel_q;
    underrun_d = underrun_q;
    rec_cnt_d  = rec_cnt_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_load) begin
          fn_sel_d = cfg_fn;
        end
        if (fifo_count >= THRESH) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rdata;
          byte_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        // busy holds shift, byte_cnt and iot_in; only in_en drops.
        if (!busy) begin
          in_en_d    = 1'b1;
          iot_in_d   = shift_q[127:120];
          shift_d    = {shift_q[119:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            rec_cnt_d = rec_cnt_q + 16'd1;
            // Reload in the same cycle so byte 0 of the next record follows without a bubble.
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              shift_d    = fifo_rdata;
              byte_cnt_d = '0;
            end else begin
              underrun_d = 1'b1;
              state_d    = StHalt;
            end
          end
        end
      end
      StHalt: begin
        // Downstream byte counter cannot resynchronise; stay here until reset.
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      in_en_q    <= 1'b0;
      iot_in_q   <= '0;
      fn_sel_q   <= '0;
      underrun_q <= 1'b0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      in_en_q    <= in_en_d;
      iot_in_q   <= iot_in_d;
      fn_sel_q   <= fn_sel_d;
      underrun_q <= underrun_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  assign in_en    = in_en_q;
  assign iot_in   = iot_in_q;
  assign fn_sel   = fn_sel_q;
  assign underrun = underrun_q;
  assign rec_cnt  = rec_cnt_q;

endmodule

// File: tb/tb_iot_stream_feeder.sv
// Bench for iot_stream_feeder.
// Instance a (START_THRESH=1) runs a cycle-by-cycle vector table; instance b
// (START_THRESH=2) is checked every cycle against a queue-based record model
// while directed sequences and random traffic are applied.
module tb_iot_stream_feeder;
  import iotdf_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned THRESH_B = 2;
  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_s_valid, a_s_ready, a_cfg_load, a_busy, a_in_en, a_underrun;
  logic [127:0] a_s_data;
  logic [2:0]   a_cfg_fn, a_fn_sel;
  logic [7:0]   a_iot_in;
  logic [15:0]  a_rec_cnt;

  logic         b_s_valid, b_s_ready, b_cfg_load, b_busy, b_in_en, b_underrun;
  logic [127:0] b_s_data;
  logic [2:0]   b_cfg_fn, b_fn_sel;
  logic [7:0]   b_iot_in;
  logic [15:0]  b_rec_cnt;

  iot_stream_feeder #(.DEPTH(DEPTH), .START_THRESH(1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .cfg_fn(a_cfg_fn), .cfg_load(a_cfg_load), .busy(a_busy), .in_en(a_in_en),
    .iot_in(a_iot_in), .fn_sel(a_fn_sel), .underrun(a_underrun), .rec_cnt(a_rec_cnt)
  );

  iot_stream_feeder #(.DEPTH(DEPTH), .START_THRESH(THRESH_B)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .cfg_fn(b_cfg_fn), .cfg_load(b_cfg_load), .busy(b_busy), .in_en(b_in_en),
    .iot_in(b_iot_in), .fn_sel(b_fn_sel), .underrun(b_underrun), .rec_cnt(b_rec_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for instance b ----------------
  logic [127:0] m_fifo[$];
  logic [127:0] m_cur;
  int           m_pos, m_bytes, m_occ;
  bit           m_send, m_halt, m_acc;
  logic         m_in_en, m_und;
  logic [7:0]   m_byte;
  logic [2:0]   m_fn;
  logic [15:0]  m_rec;

  task automatic model_reset();
    m_fifo.delete();
    m_cur = '0; m_pos = 0; m_bytes = 0;
    m_send = 0; m_halt = 0;
    m_in_en = 0; m_und = 0; m_byte = '0; m_fn = '0; m_rec = '0;
  endtask

  // One clock of the feeder: decisions use the occupancy seen before this edge,
  // and a record accepted this edge becomes visible only afterwards.
  task automatic model_step();
    m_occ   = m_fifo.size();
    m_acc   = b_s_valid && (m_occ < DEPTH);
    m_in_en = 1'b0;
    if (!m_send && !m_halt) begin
      if (b_cfg_load) m_fn = b_cfg_fn;
      if (m_occ >= THRESH_B) begin
        m_cur  = m_fifo.pop_front();
        m_pos  = 0;
        m_send = 1;
      end
    end else if (m_send && !b_busy) begin
      m_in_en = 1'b1;
      m_byte  = 8'(m_cur >> (8 * (15 - m_pos)));
      m_pos++;
      m_bytes++;
      if (m_pos == BYTES_PER_REC) begin
        m_rec++;
        if (m_occ > 0) begin
          m_cur = m_fifo.pop_front();
          m_pos = 0;
        end else begin
          m_und  = 1'b1;
          m_send = 0;
          m_halt = 1;
        end
      end
    end
    if (m_acc) m_fifo.push_back(b_s_data);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  bit chk_b = 0;
  always @(negedge clk) begin
    if (chk_b && !rst) begin
      chk("b_in_en",    128'(b_in_en),    128'(m_in_en));
      chk("b_iot_in",   128'(b_iot_in),   128'(m_byte));
      chk("b_fn_sel",   128'(b_fn_sel),   128'(m_fn));
      chk("b_underrun", 128'(b_underrun), 128'(m_und));
      chk("b_rec_cnt",  128'(b_rec_cnt),  128'(m_rec));
      chk("b_s_ready",  128'(b_s_ready),  128'(m_fifo.size() < DEPTH));
    end
  end

  // ---------------- vector table for instance a ----------------
  typedef struct {
    logic         s_valid;
    logic [127:0] s_data;
    logic         cfg_load;
    logic [2:0]   cfg_fn;
    logic         e_in_en;
    logic [7:0]   e_iot;
    logic [2:0]   e_fn;
    logic         e_und;
    logic [15:0]  e_rec;
    logic         e_ready;
  } vec_t;

  vec_t vecs[NV];

  task automatic b_idle();
    b_s_valid = 0; b_s_data = '0; b_cfg_load = 0; b_cfg_fn = '0; b_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b_idle();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0]   fn_codes[7];
  logic [127:0] recs[8];
  logic [127:0] rec_a, r1, r2;
  int idx, run, best, bytes, gaps, stalls, cyc;
  bit acc, saw_full;
  logic und_mid;
  logic [7:0] last_of_first;

  initial begin
    fn_codes = '{FN_MAX, FN_MIN, FN_AVG, FN_EXT, FN_EXC, FN_PMAX, FN_PMIN};
    rec_a = 128'h000102030405060708090a0b0c0d0e0f;

    for (int i = 0; i < NV; i++) begin
      vecs[i] = '{s_valid: 1'b0, s_data: '0, cfg_load: 1'b0, cfg_fn: '0, e_in_en: 1'b0,
                  e_iot: '0, e_fn: FN_AVG, e_und: 1'b0, e_rec: '0, e_ready: 1'b1};
    end
    vecs[0].s_valid  = 1'b1;
    vecs[0].s_data   = rec_a;
    vecs[0].cfg_load = 1'b1;
    vecs[0].cfg_fn   = FN_AVG;
    for (int i = 2; i < 18; i++) begin
      vecs[i].e_in_en = 1'b1;
      vecs[i].e_iot   = 8'(i - 2);
      vecs[i].e_und   = (i == 17);
      vecs[i].e_rec   = 16'(i == 17);
    end
    vecs[6].cfg_load = 1'b1;  // ignored mid-stream
    vecs[6].cfg_fn   = FN_PMAX;
    for (int i = 18; i < NV; i++) begin
      vecs[i].e_iot = 8'h0f;
      vecs[i].e_und = 1'b1;
      vecs[i].e_rec = 16'd1;
    end
    vecs[18].cfg_load = 1'b1;  // ignored in halt
    vecs[18].cfg_fn   = FN_PMIN;
    for (int i = 19; i < NV; i++) begin
      vecs[i].s_valid = 1'b1;
      vecs[i].s_data  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].e_ready = (i < 22);
    end

    rst = 1'b1;
    a_s_valid = 0; a_s_data = '0; a_cfg_load = 0; a_cfg_fn = '0; a_busy = 0;
    b_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_in_en",  128'(a_in_en),    128'(0));
    chk("rst_a_iot_in", 128'(a_iot_in),   128'(0));
    chk("rst_a_fn",     128'(a_fn_sel),   128'(0));
    chk("rst_a_und",    128'(a_underrun), 128'(0));
    chk("rst_a_rec",    128'(a_rec_cnt),  128'(0));
    chk("rst_a_ready",  128'(a_s_ready),  128'(1));
    chk("rst_b_in_en",  128'(b_in_en),    128'(0));
    chk("rst_b_ready",  128'(b_s_ready),  128'(1));
    rst = 1'b0;
    chk_b = 1;

    // Single record with START_THRESH=1, then halt; cfg_load ignored outside idle.
    for (int i = 0; i < NV; i++) begin
      a_s_valid  = vecs[i].s_valid;
      a_s_data   = vecs[i].s_data;
      a_cfg_load = vecs[i].cfg_load;
      a_cfg_fn   = vecs[i].cfg_fn;
      tick();
      chk($sformatf("vec%0d_in_en", i), 128'(a_in_en),    128'(vecs[i].e_in_en));
      chk($sformatf("vec%0d_iot", i),   128'(a_iot_in),   128'(vecs[i].e_iot));
      chk($sformatf("vec%0d_fn", i),    128'(a_fn_sel),   128'(vecs[i].e_fn));
      chk($sformatf("vec%0d_und", i),   128'(a_underrun), 128'(vecs[i].e_und));
      chk($sformatf("vec%0d_rec", i),   128'(a_rec_cnt),  128'(vecs[i].e_rec));
      chk($sformatf("vec%0d_ready", i), 128'(a_s_ready),  128'(vecs[i].e_ready));
    end
    a_s_valid = 0; a_cfg_load = 0;

    // cfg_load in idle takes effect one cycle later.
    b_cfg_load = 1; b_cfg_fn = FN_PMIN;
    tick();
    chk("b_fn_idle_load", 128'(b_fn_sel), 128'(FN_PMIN));
    b_idle();

    // Eight records at full rate: one gapless 128-byte run, FIFO fills.
    do_reset();
    foreach (recs[k]) recs[k] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; run = 0; best = 0; saw_full = 0;
    for (int c = 0; c < 400 && !m_halt; c++) begin
      b_s_valid = (idx < 8);
      b_s_data  = recs[idx % 8];
      acc = b_s_valid && (m_fifo.size() < DEPTH);
      tick();
      if (acc) idx++;
      if (b_in_en) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (!b_s_ready) saw_full = 1;
    end
    b_idle();
    chk("burst_pushed",  128'(idx),        128'(8));
    chk("burst_run",     128'(best),       128'(128));
    chk("burst_rec_cnt", 128'(b_rec_cnt),  128'(8));
    chk("burst_und",     128'(b_underrun), 128'(1));
    chk("burst_full",    128'(saw_full),   128'(1));

    // busy for three cycles at byte 5 of the first record.
    do_reset();
    r1 = {{15{8'hAA}}, 8'h55};
    b_s_valid = 1; b_s_data = r1;
    tick();
    b_s_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    b_s_valid = 0;
    bytes = 0; gaps = 0; stalls = 0; und_mid = 1'bx; last_of_first = 'x;
    for (int c = 0; c < 200 && bytes < 32; c++) begin
      b_busy = (bytes == 5 && stalls < 3);
      if (b_busy) stalls++;
      tick();
      if (b_in_en) begin
        bytes++;
        if (bytes == 16) begin
          und_mid = b_underrun;
          last_of_first = b_iot_in;
        end
      end else if (bytes > 0) begin
        gaps++;
      end
    end
    b_busy = 0;
    chk("busy_bytes",   128'(bytes),         128'(32));
    chk("busy_gaps",    128'(gaps),          128'(3));
    chk("busy_no_und",  128'(und_mid),       128'(0));
    chk("busy_last",    128'(last_of_first), 128'(8'h55));
    chk("busy_rec_cnt", 128'(b_rec_cnt),     128'(2));

    // Random traffic at three push densities.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        b_s_valid  = ($urandom_range(0, 9) < ((r == 0) ? 5 : (r == 1) ? 1 : 9));
        b_s_data   = {$urandom, $urandom, $urandom, $urandom};
        b_busy     = ($urandom_range(0, 3) == 0);
        b_cfg_load = ($urandom_range(0, 9) == 0);
        b_cfg_fn   = fn_codes[$urandom_range(0, 6)];
        tick();
      end
      b_idle();
    end

    // Reset at byte 9 of record 2, then a fresh stream.
    do_reset();
    b_s_valid = 1;
    for (int c = 0; c < 200 && m_bytes < 42; c++) begin
      b_s_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("mid_rec_cnt", 128'(b_rec_cnt), 128'(2));
    chk("mid_in_en",   128'(b_in_en),   128'(1));
    rst = 1'b1;
    b_idle();
    #1;
    chk("mid_rst_in_en", 128'(b_in_en),    128'(0));
    chk("mid_rst_iot",   128'(b_iot_in),   128'(0));
    chk("mid_rst_ready", 128'(b_s_ready),  128'(1));
    chk("mid_rst_rec",   128'(b_rec_cnt),  128'(0));
    chk("mid_rst_und",   128'(b_underrun), 128'(0));
    tick();
    rst = 1'b0;
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    b_s_valid = 1; b_s_data = r1;
    tick();
    b_s_data = r2;
    tick();
    b_s_valid = 0;
    cyc = 0;
    while (!b_in_en && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("fresh_started", 128'(b_in_en),  128'(1));
    chk("fresh_byte0",   128'(b_iot_in), 128'(r1[127:120]));
    repeat (40) tick();

    chk_b = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
